// File: rtl/alu_fifo.sv
// Combinational ALU whose result can be pushed into a DEPTH-word FIFO; the read data is registered (1 clock).
// A write while full and a read while empty are dropped and set sticky ovf/udf; when full, a same-cycle read still drains.
module alu_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel,
  input  logic             en,
  input  logic             rd,
  input  logic             clr_err,
  output logic [WIDTH-1:0] datoSalida,
  output logic             zeroFlag,
  output logic             carry,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf
);

  logic [WIDTH-1:0] aluRes;
  logic             carryOut;
  logic [WIDTH:0]   ext;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             wrOk;
  logic             rdOk;

  always_comb begin
    aluRes   = '0;
    carryOut = 1'b0;
    ext      = '0;
    case (sel)
      3'b000: begin
        ext      = {1'b0, a} + {1'b0, b};
        aluRes   = ext[WIDTH-1:0];
        carryOut = ext[WIDTH];
      end
      3'b001: begin
        // the extra top bit of the widened difference is the borrow
        ext      = {1'b0, a} - {1'b0, b};
        aluRes   = ext[WIDTH-1:0];
        carryOut = ext[WIDTH];
      end
      3'b010: aluRes = a & b;
      3'b011: aluRes = a | b;
      3'b100: aluRes = a ^ b;
      3'b101: aluRes = ~a;
      3'b110: begin
        aluRes   = {a[WIDTH-2:0], 1'b0};
        carryOut = a[WIDTH-1];
      end
      default: aluRes = b;
    endcase
  end

  assign zeroFlag = (aluRes == '0);
  assign carry    = carryOut;
  assign empty    = (count == '0);
  assign full     = (count == (AW+1)'(DEPTH));
  assign wrOk     = en && !full;
  assign rdOk     = rd && !empty;

  // storage is not reset; rst_n gates it so nothing lands while reset is held
  always_ff @(posedge clk) begin
    if (wrOk && rst_n) mem[wptr] <= aluRes;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      datoSalida <= '0;
      ovf        <= 1'b0;
      udf        <= 1'b0;
    end else begin
      if (wrOk) wptr <= wptr + 1'b1;
      if (rdOk) begin
        rptr       <= rptr + 1'b1;
        datoSalida <= mem[rptr];
      end
      case ({wrOk, rdOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // an error in the same cycle wins over the clear
      if (en && full)      ovf <= 1'b1;
      else if (clr_err)    ovf <= 1'b0;
      if (rd && empty)     udf <= 1'b1;
      else if (clr_err)    udf <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_fifo.sv
// Randomised and directed bench for alu_fifo (WIDTH=8, DEPTH=4) against a queue-based model.
module tb_alu_fifo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] aIn = '0;
  logic [7:0] bIn = '0;
  logic [2:0] selIn = '0;
  logic       enIn = 1'b0;
  logic       rdIn = 1'b0;
  logic       clrIn = 1'b0;
  logic [7:0] datoSalida;
  logic       zeroFlag, carry, full, empty, ovf, udf;
  logic [2:0] count;

  int nTests = 0;
  int nFail  = 0;
  logic lastZf, lastCy;

  // reference model state
  logic [7:0] q[$];
  int mDout = 0;
  int mOvf  = 0;
  int mUdf  = 0;
  int pre, aluV, resV, cyV;
  bit wrV, rdV;

  alu_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .a(aIn), .b(bIn), .sel(selIn), .en(enIn), .rd(rdIn),
    .clr_err(clrIn), .datoSalida(datoSalida), .zeroFlag(zeroFlag), .carry(carry),
    .full(full), .empty(empty), .count(count), .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nTests++;
    if (act != exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // returns result in bits 7:0 and carry/borrow in bit 8
  function automatic int aluModel(input int x, input int y, input int s);
    int r, c;
    c = 0;
    case (s)
      0: begin r = (x + y) % 256; c = (x + y > 255); end
      1: begin r = (x - y + 256) % 256; c = (x < y); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: r = 255 - x;
      6: begin r = (x * 2) % 256; c = (x >= 128); end
      default: r = y;
    endcase
    return r + c * 256;
  endfunction

  always @(negedge rst_n) begin
    q.delete();
    mDout = 0;
    mOvf  = 0;
    mUdf  = 0;
  end

  // combinational checks and model update on the active edge (inputs stable since the previous negedge)
  always @(posedge clk) begin
    aluV = aluModel(int'(aIn), int'(bIn), int'(selIn));
    resV = aluV % 256;
    cyV  = aluV / 256;
    chk("zeroFlag", int'(zeroFlag), int'(resV == 0));
    chk("carry", int'(carry), cyV);
    if (rst_n) begin
      pre = q.size();
      wrV = enIn && pre < 4;
      rdV = rdIn && pre > 0;
      if (rdV) mDout = int'(q.pop_front());
      if (wrV) q.push_back(resV[7:0]);
      if (enIn && pre == 4) mOvf = 1;
      else if (clrIn) mOvf = 0;
      if (rdIn && pre == 0) mUdf = 1;
      else if (clrIn) mUdf = 0;
    end
  end

  // registered outputs checked mid-cycle
  always @(negedge clk) begin
    chk("count", int'(count), q.size());
    chk("empty", int'(empty), int'(q.size() == 0));
    chk("full", int'(full), int'(q.size() == 4));
    chk("datoSalida", int'(datoSalida), mDout);
    chk("ovf", int'(ovf), mOvf);
    chk("udf", int'(udf), mUdf);
  end

  task automatic cyc(input int ai, input int bi, input int s, input int e, input int r, input int c);
    @(negedge clk);
    aIn   = ai[7:0];
    bIn   = bi[7:0];
    selIn = s[2:0];
    enIn  = e[0];
    rdIn  = r[0];
    clrIn = c[0];
    #1;
    lastZf = zeroFlag;
    lastCy = carry;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    chk("rst count", int'(count), 0);
    chk("rst empty", int'(empty), 1);
    chk("rst full", int'(full), 0);
    chk("rst dout", int'(datoSalida), 0);
    chk("rst ovf", int'(ovf), 0);
    chk("rst udf", int'(udf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // single write then read
    cyc(74, 0, 0, 1, 0, 0);
    chk("w74 count", int'(count), 1);
    chk("w74 empty", int'(empty), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("r74 dout", int'(datoSalida), 74);
    chk("r74 empty", int'(empty), 1);

    // ALU flags at write time, then readback order
    cyc(200, 100, 0, 1, 0, 0);
    chk("add carry", int'(lastCy), 1);
    cyc(5, 6, 1, 1, 0, 0);
    chk("sub borrow", int'(lastCy), 1);
    cyc(8'h0F, 8'hF0, 2, 1, 0, 0);
    chk("and zero", int'(lastZf), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rd 44", int'(datoSalida), 44);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rd 255", int'(datoSalida), 255);
    cyc(0, 0, 0, 0, 1, 0);
    chk("rd 0", int'(datoSalida), 0);

    // overflow and underflow
    for (int i = 1; i <= 5; i++) begin
      cyc(0, i, 7, 1, 0, 0);
      if (i == 4) chk("full after 4", int'(full), 1);
    end
    chk("ovf set", int'(ovf), 1);
    chk("count at ovf", int'(count), 4);
    for (int i = 1; i <= 5; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      if (i <= 4) chk("drain word", int'(datoSalida), i);
    end
    chk("udf set", int'(udf), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("clr ovf", int'(ovf), 0);
    chk("clr udf", int'(udf), 0);

    // simultaneous read/write at full and at empty
    for (int i = 0; i < 4; i++) cyc(0, 10 + i, 7, 1, 0, 0);
    cyc(0, 99, 7, 1, 1, 0);
    chk("full rw count", int'(count), 3);
    chk("full rw dout", int'(datoSalida), 10);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1, 0);
      chk("full rw drop", int'(datoSalida), 11 + i);
    end
    cyc(0, 77, 7, 1, 1, 0);
    chk("empty rw count", int'(count), 1);
    chk("empty rw dout", int'(datoSalida), 13);
    cyc(0, 0, 0, 0, 1, 1);
    chk("empty rw word", int'(datoSalida), 77);

    // steady alternation wraps the pointers
    for (int i = 0; i < 10; i++) begin
      cyc(0, i * 7 + 3, 7, 1, 0, 0);
      cyc(0, 0, 0, 0, 1, 0);
      chk("alt word", int'(datoSalida), i * 7 + 3);
    end
    cyc(0, 50, 7, 1, 0, 0);
    cyc(0, 51, 7, 1, 0, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst count", int'(count), 0);
    chk("mid rst empty", int'(empty), 1);
    chk("mid rst dout", int'(datoSalida), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // random traffic, alternating write-heavy and read-heavy phases
    for (int i = 0; i < 1600; i++) begin
      int wp;
      wp = ((i / 40) % 2 == 0) ? 70 : 30;
      cyc($urandom, $urandom, $urandom_range(0, 7),
          int'($urandom_range(0, 99) < wp), int'($urandom_range(0, 99) < 100 - wp),
          int'($urandom_range(0, 99) < 5));
    end

    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/alu_fifo.md
ALU_FIFO -- requirements
Module: alu_fifo

Interface
REQ-001 Parameter WIDTH, default 8, datapath width of operands, ALU result and stored words.
REQ-002 Parameter DEPTH, default 64, number of storage words; power of two, minimum 2.
REQ-003 Local parameter AW = clog2(DEPTH), pointer width; count width is AW+1.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 a  input  WIDTH  ALU operand A.
REQ-007 b  input  WIDTH  ALU operand B.
REQ-008 sel  input  3  ALU operation select.
REQ-009 en  input  1  write request: store the ALU result.
REQ-010 rd  input  1  read request: pop the oldest stored word.
REQ-011 clr_err  input  1  synchronous clear of the sticky error flags.
REQ-012 datoSalida  output  WIDTH  registered read data.
REQ-013 zeroFlag  output  1  combinational: current ALU result == 0.
REQ-014 carry  output  1  combinational: carry-out of add, borrow of sub, shifted-out bit of shl; 0 otherwise.
REQ-015 full / empty  output  1 each  occupancy flags.
REQ-016 count  output  AW+1  number of stored words, 0..DEPTH.
REQ-017 ovf / udf  output  1 each  sticky write-when-full and read-when-empty error flags.

Function
REQ-018 The ALU shall be combinational: sel 000 a+b, 001 a-b, 010 a&b, 011 a|b, 100 a^b, 101 ~a, 110 a<<1, 111 b; result truncated to WIDTH bits.
REQ-019 A write shall be accepted when en=1 and full=0: mem[wptr] <= ALU result, wptr <= wptr+1 modulo DEPTH.
REQ-020 A read shall be accepted when rd=1 and empty=0: datoSalida <= mem[rptr] one cycle after the edge, rptr <= rptr+1 modulo DEPTH (latency 1 clock).
REQ-021 datoSalida shall hold its last value on any cycle without an accepted read.
REQ-022 count shall increment on write-only, decrement on read-only, and stay unchanged when both are accepted in the same cycle.
REQ-023 empty = (count==0); full = (count==DEPTH); both derived from count, never both 1.
REQ-024 When full and en=1 and rd=1: the read is accepted, the write is rejected (no same-cycle slot reuse); count decrements.
REQ-025 When empty and en=1 and rd=1: the write is accepted, the read is rejected (no bypass); count becomes 1.
REQ-026 A rejected write (en=1, full=1) shall set ovf; a rejected read (rd=1, empty=1) shall set udf; storage, pointers and count unchanged.
REQ-027 clr_err=1 shall clear ovf and udf on the next edge; a same-cycle error event has priority and sets the flag.
REQ-028 Pointers shall wrap from DEPTH-1 to 0 without affecting count or flags.

Reset
REQ-029 rst_n=0 shall immediately clear wptr, rptr, count, datoSalida, ovf, udf; empty=1, full=0.
REQ-030 Storage contents need not be reset; reset mid-operation discards all stored words.
REQ-031 No write or read shall be accepted on an edge while rst_n=0.

Verification (bench with WIDTH=8, DEPTH=4)
REQ-032 Reset, then write a=74,b=0,sel=000 -> count=1, empty=0; rd next cycle -> datoSalida=74 one clock later, empty=1.
REQ-033 Write 200+100 (sel 000), 5-6 (sel 001), 0x0F&0xF0 (sel 010) -> carry=1, carry=1, zeroFlag=1 at write; read back 44, 255, 0 in order.
REQ-034 Five writes -> full=1 after fourth, fifth sets ovf=1, count=4; four reads return first four results; fifth read sets udf=1.
REQ-035 Fill to 4, then en=1 rd=1 -> count=3, oldest word output, write dropped; from empty, en=1 rd=1 -> count=1, datoSalida unchanged.
REQ-036 Write/read 10 words in steady alternation -> pointers wrap twice, data order preserved; assert rst_n low mid-stream -> count=0, empty=1, datoSalida=0 immediately.
